// File: rtl/sram_arbiter.sv
// Arbitrates one single-port SRAM between the CPU and a DMA engine: fixed CPU
// priority, bounded by a DMA starvation guard and a DMA burst lock.
module sram_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic              dma_lock,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [1:0]        owner
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CPU        = 2'd1,
        DMA        = 2'd2,
        DMA_LOCKED = 2'd3
    } owner_t;

    localparam int                CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    owner_t            state;
    owner_t            state_nxt;
    logic [CNT_W-1:0]  starve_cnt;
    logic [CNT_W-1:0]  starve_nxt;
    logic              rd_cpu;
    logic              rd_dma;
    logic              grant_cpu;
    logic              grant_dma;

    // State register, starvation counter and read-return pipe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            rd_cpu     <= 1'b0;
            rd_dma     <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            rd_cpu     <= grant_cpu & ~cpu_we;
            rd_dma     <= grant_dma & ~dma_we;
        end
    end

    always_comb begin
        state_nxt  = IDLE;
        starve_nxt = starve_cnt;
        if (grant_cpu) begin
            state_nxt = CPU;
        end else if (grant_dma) begin
            state_nxt = dma_lock ? DMA_LOCKED : DMA;
        end
        if (!dma_req || grant_dma) begin
            starve_nxt = '0;
        end else if (starve_cnt != LIMIT) begin
            starve_nxt = starve_cnt + CNT_W'(1);
        end
    end

    // Grant decision; everything is held at zero while reset is asserted.
    always_comb begin
        grant_cpu  = 1'b0;
        grant_dma  = 1'b0;
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (reset) begin
            if (state == DMA_LOCKED && dma_req) begin
                grant_dma = 1'b1;
            end else if (dma_req && starve_cnt == LIMIT) begin
                grant_dma = 1'b1;
            end else if (cpu_req) begin
                grant_cpu = 1'b1;
            end else if (dma_req) begin
                grant_dma = 1'b1;
            end
        end
        if (grant_cpu) begin
            sram_en    = 1'b1;
            sram_we    = cpu_we;
            sram_addr  = cpu_addr;
            sram_wdata = cpu_we ? cpu_wdata : '0;
        end else if (grant_dma) begin
            sram_en    = 1'b1;
            sram_we    = dma_we;
            sram_addr  = dma_addr;
            sram_wdata = dma_we ? dma_wdata : '0;
        end
    end

    assign cpu_gnt    = grant_cpu;
    assign dma_gnt    = grant_dma;
    assign cpu_rvalid = rd_cpu;
    assign dma_rvalid = rd_dma;
    assign cpu_rdata  = rd_cpu ? sram_rdata : '0;
    assign dma_rdata  = rd_dma ? sram_rdata : '0;
    assign owner      = state;

endmodule
